sin_wave_ctrl: RTL and testbench
================================

Name: sin_wave_ctrl

Overview:
Sequencer for the 9-bit sine lookup block (`sin_wave`: `clk`, `count[8:0]` in, `val[8:0]` out). It generates the LUT address stream from a phase accumulator with a programmable frequency word and sample-rate prescaler, in continuous or N-period burst mode. It flags which LUT outputs are valid samples so downstream DAC/plot logic consumes exactly one value per sample tick.

Parameters:
- PHASE_W, 16: phase accumulator width. `count` is `phase[PHASE_W-1 -: 9]`. Must be >= 9.
- DIV_W, 16: prescaler width.
- LUT_LAT, 1: clk cycles from a `count` change to the matching `val`. Must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  latch cfg_* inputs. Honoured only in IDLE.
- cfg_freq  in  PHASE_W  phase increment per sample tick.
- cfg_div  in  DIV_W  one sample tick every cfg_div+1 clocks.
- cfg_cycles  in  8  burst length in waveform periods. 0 is treated as 1.
- cfg_burst  in  1  1 = burst mode, 0 = continuous.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle stop request.
- count  out  9  LUT address, driven to `sin_wave.count`.
- sample_strobe  out  1  1-cycle pulse: `count` holds a new sample address.
- wrap  out  1  1-cycle pulse, coincident with sample_strobe, when the phase add overflowed.
- sample_valid  out  1  sample_strobe delayed LUT_LAT cycles. Aligned with `val`.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  1-cycle pulse on return to IDLE after RUN.

Behaviour:
- Reset (any cycle, including mid-run):
  - state = IDLE; phase = 0, so count = 0.
  - Prescaler, wrap counter and the delay line for pending valids are cleared.
  - Config registers are cleared (freq = 0, div = 0, cycles = 0, burst = 0).
  - All outputs are 0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_we latches all cfg_* on the next edge.
  - start moves to RUN on the next edge. That same edge sets phase = 0, prescaler = 0, wrap counter = 0, and asserts sample_strobe for one cycle (first sample is at phase 0).
  - stop is ignored in IDLE. start together with stop in IDLE: start wins.
- RUN:
  - The prescaler counts 0..div. When prescaler == div there is a tick, and the prescaler returns to 0. With div = 0 every cycle is a tick.
  - On a tick: phase <= (phase + freq) mod 2^PHASE_W. sample_strobe = 1 in the following cycle, coincident with the new count.
  - wrap = 1 with that strobe if the add carried out of PHASE_W. Each wrap increments the 8-bit wrap counter.
  - Burst end: in burst mode, a tick whose add carries and whose wrap counter + 1 reaches max(cfg_cycles, 1) does the following:
    - goes to DRAIN;
    - leaves phase unchanged;
    - emits no strobe and no wrap pulse.
  - stop goes to DRAIN on the next edge. stop in the same cycle as a tick: stop wins and no strobe is produced.
  - start and cfg_we are ignored in RUN.
  - freq = 0: count is held constant and wrap never fires. A burst then only ends via stop.
- DRAIN:
  - Lasts exactly LUT_LAT cycles so in-flight sample_valid pulses still emerge.
  - No new strobes. start, stop and cfg_we are ignored.
  - At exit: phase <= 0, done = 1 for one cycle, state = IDLE (busy falls the same edge done rises).
- Output timing: count, sample_strobe, wrap, busy and done are all registered outputs. sample_valid is a pure LUT_LAT-stage shift of sample_strobe, also cleared by rst.

Test Plan:
1. Reset: assert rst for 3 cycles mid-RUN -> next cycle count = 0, busy = 0, sample_strobe = sample_valid = wrap = done = 0. A later start with no cfg_we produces constant count = 0.
2. Continuous run:
   - Stimulus: cfg freq = 0x0080, div = 0, burst = 0, then start.
   - count = 0, 1, 2, ..., 511, 0 on consecutive cycles with sample_strobe high every cycle.
   - wrap is high only on the cycle count returns to 0.
   - sample_valid equals sample_strobe delayed 1 cycle.
3. Prescaler: freq = 0x0080, div = 3 -> sample_strobe every 4th cycle and count advances by 1 per strobe.
4. Burst:
   - Stimulus: freq = 0x4000, div = 0, burst = 1, cycles = 2.
   - count = 0, 128, 256, 384, 0 (wrap = 1), 128, 256, 384 gives 8 strobes and 1 wrap pulse.
   - Then DRAIN for 1 cycle, done pulses once, busy = 0, count = 0.
5. Stop and config protection:
   - stop issued in the same cycle as a tick (div = 3) -> no strobe that tick, done exactly LUT_LAT + 1 cycles after stop.
   - cfg_we pulsed during RUN -> step size unchanged.
6. Start/stop collision: start and stop together in IDLE -> enters RUN; a second start during RUN has no effect on count.

Source files
------------

// File: rtl/sin_wave_ctrl.sv
// sin_wave_ctrl
// Address sequencer for the 9-bit sine lookup block. A phase accumulator
// steps by a programmable frequency word once per sample tick (one tick every
// div+1 clocks). The top 9 phase bits form the LUT address. Runs continuously
// or for a fixed number of waveform periods (burst mode).
//
// Ports:
//   clk, rst         system clock (rising edge), synchronous active-high reset
//   cfg_we           latch all cfg_* inputs (only while idle)
//   cfg_freq         phase increment per sample tick
//   cfg_div          prescaler: one sample tick every cfg_div+1 clocks
//   cfg_cycles       burst length in waveform periods (0 behaves as 1)
//   cfg_burst        1 = burst mode, 0 = continuous
//   start, stop      single-cycle run control requests
//   count            LUT address (to sin_wave.count)
//   sample_strobe    count holds a new sample address this cycle
//   wrap             phase add overflowed (coincident with sample_strobe)
//   sample_valid     sample_strobe delayed by LUT_LAT, aligned with LUT val
//   busy             sequencer is running or draining
//   done             one-cycle pulse on return to idle

module sin_wave_ctrl #(
    parameter int PHASE_W = 16,
    parameter int DIV_W   = 16,
    parameter int LUT_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [7:0]         cfg_cycles,
    input  logic               cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic [8:0]         count,
    output logic               sample_strobe,
    output logic               wrap,
    output logic               sample_valid,
    output logic               busy,
    output logic               done
);

    // Elaboration-time parameter sanity checks
    if (PHASE_W < 9) begin : g_bad_phase_w
        $error("sin_wave_ctrl: PHASE_W must be >= 9");
    end
    if (LUT_LAT < 1) begin : g_bad_lut_lat
        $error("sin_wave_ctrl: LUT_LAT must be >= 1");
    end

    localparam int DRAIN_W = $clog2(LUT_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    // Configuration registers
    logic [PHASE_W-1:0] freq_q, freq_next;
    logic [DIV_W-1:0]   div_q, div_next;
    logic [7:0]         cycles_q, cycles_next;
    logic               burst_q, burst_next;

    // Datapath registers
    logic [PHASE_W-1:0] phase, phase_next;
    logic [DIV_W-1:0]   presc, presc_next;
    logic [7:0]         wcnt, wcnt_next;
    logic [DRAIN_W-1:0] dcnt, dcnt_next;
    logic               strobe_next;
    logic               wrap_next;
    logic               done_next;
    logic [LUT_LAT-1:0] valid_pipe;

    // Phase add with carry-out; the carry is what marks a completed period
    logic [PHASE_W-1:0] phase_sum;
    logic               phase_carry;
    logic               tick;
    logic [7:0]         cycles_eff;
    logic               burst_last;

    assign {phase_carry, phase_sum} = {1'b0, phase} + {1'b0, freq_q};
    assign tick       = (presc == div_q);
    assign cycles_eff = (cycles_q == 8'd0) ? 8'd1 : cycles_q;

    // The wrap counter is only 8 bits, so compare in 9 bits to keep the +1
    // from rolling over when cycles_eff is 255.
    assign burst_last = burst_q && phase_carry
                        && (({1'b0, wcnt} + 9'd1) >= {1'b0, cycles_eff});

    assign count        = phase[PHASE_W-1 -: 9];
    assign sample_valid = valid_pipe[LUT_LAT-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_next  = state;
        phase_next  = phase;
        presc_next  = presc;
        wcnt_next   = wcnt;
        dcnt_next   = dcnt;
        strobe_next = 1'b0;
        wrap_next   = 1'b0;
        done_next   = 1'b0;
        freq_next   = freq_q;
        div_next    = div_q;
        cycles_next = cycles_q;
        burst_next  = burst_q;

        case (state)
            IDLE: begin
                if (cfg_we) begin
                    freq_next   = cfg_freq;
                    div_next    = cfg_div;
                    cycles_next = cfg_cycles;
                    burst_next  = cfg_burst;
                end
                // start wins over a simultaneous stop; first sample is phase 0
                if (start) begin
                    state_next  = RUN;
                    phase_next  = '0;
                    presc_next  = '0;
                    wcnt_next   = '0;
                    strobe_next = 1'b1;
                end
            end

            RUN: begin
                if (stop) begin
                    state_next = DRAIN;
                    dcnt_next  = '0;
                end else if (tick) begin
                    presc_next = '0;
                    // The period-completing add of the final burst period is
                    // discarded so the address never shows the restart point.
                    if (burst_last) begin
                        state_next = DRAIN;
                        dcnt_next  = '0;
                    end else begin
                        phase_next  = phase_sum;
                        strobe_next = 1'b1;
                        wrap_next   = phase_carry;
                        wcnt_next   = wcnt + {7'd0, phase_carry};
                    end
                end else begin
                    presc_next = presc + DIV_W'(1);
                end
            end

            DRAIN: begin
                // Hold off idle until every in-flight valid has emerged
                if (dcnt == DRAIN_W'(LUT_LAT - 1)) begin
                    state_next = IDLE;
                    phase_next = '0;
                    done_next  = 1'b1;
                end else begin
                    dcnt_next = dcnt + DRAIN_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath, configuration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            phase         <= '0;
            presc         <= '0;
            wcnt          <= '0;
            dcnt          <= '0;
            freq_q        <= '0;
            div_q         <= '0;
            cycles_q      <= '0;
            burst_q       <= 1'b0;
            sample_strobe <= 1'b0;
            wrap          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            phase         <= phase_next;
            presc         <= presc_next;
            wcnt          <= wcnt_next;
            dcnt          <= dcnt_next;
            freq_q        <= freq_next;
            div_q         <= div_next;
            cycles_q      <= cycles_next;
            burst_q       <= burst_next;
            sample_strobe <= strobe_next;
            wrap          <= wrap_next;
            busy          <= (state_next != IDLE);
            done          <= done_next;
        end
    end

    // Delay line lining sample_strobe up with the LUT output
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= sample_strobe;
            for (int i = 1; i < LUT_LAT; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sin_wave_ctrl.sv
// tb_sin_wave_ctrl
// Self-checking bench for sin_wave_ctrl. Expected outputs come from a
// closed-form model: sample k appears k*(div+1) cycles after start at phase
// k*freq mod 2^16, a burst ends at the first sample whose period count reaches
// the requested number of periods, and a stop cuts the run on the next edge.

module tb_sin_wave_ctrl;

    localparam int PHASE_W = 16;
    localparam int DIV_W   = 16;
    localparam int LUT_LAT = 1;

    logic               clk;
    logic               rst;
    logic               cfg_we;
    logic [PHASE_W-1:0] cfg_freq;
    logic [DIV_W-1:0]   cfg_div;
    logic [7:0]         cfg_cycles;
    logic               cfg_burst;
    logic               start;
    logic               stop;
    logic [8:0]         count;
    logic               sample_strobe;
    logic               wrap;
    logic               sample_valid;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    sin_wave_ctrl #(
        .PHASE_W(PHASE_W),
        .DIV_W  (DIV_W),
        .LUT_LAT(LUT_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_freq     (cfg_freq),
        .cfg_div      (cfg_div),
        .cfg_cycles   (cfg_cycles),
        .cfg_burst    (cfg_burst),
        .start        (start),
        .stop         (stop),
        .count        (count),
        .sample_strobe(sample_strobe),
        .wrap         (wrap),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write a configuration while idle
    task automatic program_cfg(input int freq, input int div, input int cyc, input bit bst);
        @(posedge clk);
        #1;
        cfg_freq   = PHASE_W'(freq);
        cfg_div    = DIV_W'(div);
        cfg_cycles = 8'(cyc);
        cfg_burst  = bst;
        cfg_we     = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Model of whether a strobe is present at cycle u of a run ending at t_end
    function automatic bit model_strobe(input longint u, input longint t_end, input longint per);
        return (u >= 0) && (u < t_end) && ((u % per) == 0);
    endfunction

    // Start a run and compare every output each cycle against the model until
    // one cycle past done. Cycle 0 is the cycle right after the start edge.
    task automatic run_scenario(input string name, input int freq, input int div,
                                input int cyc, input bit bst, input int stop_at,
                                input int start_at, input int cfgwe_at, input bit collide,
                                output int n_strobe, output int n_wrap, output int n_done);
        longint per, t_nat, t_end, k, ncyc, e_count;
        bit e_strobe, e_wrap, e_valid, e_busy, e_done;
        n_strobe = 0;
        n_wrap   = 0;
        n_done   = 0;
        per  = longint'(div) + 1;
        ncyc = (cyc == 0) ? 1 : cyc;
        if (bst && freq != 0) begin
            t_nat = ((ncyc * 65536 + freq - 1) / freq) * per;
        end else begin
            t_nat = 64'd1_000_000_000;
        end
        t_end = t_nat;
        if (stop_at >= 0 && (longint'(stop_at) + 1) < t_nat) t_end = longint'(stop_at) + 1;
        if (t_end > 20000) begin
            errors++;
            checks++;
            $display("[TB] FAIL %s run_length got %0d required <= 20000", name, t_end);
            return;
        end

        @(posedge clk);
        #1;
        start = 1'b1;
        stop  = collide;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;

        for (longint t = 0; t <= t_end + LUT_LAT + 1; t++) begin
            @(negedge clk);
            e_strobe = 1'b0;
            e_wrap   = 1'b0;
            e_done   = 1'b0;
            e_busy   = 1'b0;
            e_count  = 0;
            if (t < t_end) begin
                k        = t / per;
                e_strobe = model_strobe(t, t_end, per);
                e_count  = ((k * freq) % 65536) >> 7;
                e_wrap   = e_strobe && (k > 0) && (((k * freq) >> 16) != (((k - 1) * freq) >> 16));
                e_busy   = 1'b1;
            end else if (t < t_end + LUT_LAT) begin
                k       = (t_end - 1) / per;
                e_count = ((k * freq) % 65536) >> 7;
                e_busy  = 1'b1;
            end else if (t == t_end + LUT_LAT) begin
                e_done = 1'b1;
            end
            e_valid = model_strobe(t - LUT_LAT, t_end, per);

            if (sample_strobe) n_strobe++;
            if (wrap) n_wrap++;
            if (done) n_done++;

            checks++;
            if (count !== 9'(e_count)) begin
                errors++;
                $display("[TB] FAIL %s t=%0d count got %0d required %0d", name, t, count, e_count);
            end
            checks++;
            if (sample_strobe !== e_strobe) begin
                errors++;
                $display("[TB] FAIL %s t=%0d sample_strobe got %b required %b", name, t, sample_strobe, e_strobe);
            end
            checks++;
            if (wrap !== e_wrap) begin
                errors++;
                $display("[TB] FAIL %s t=%0d wrap got %b required %b", name, t, wrap, e_wrap);
            end
            checks++;
            if (sample_valid !== e_valid) begin
                errors++;
                $display("[TB] FAIL %s t=%0d sample_valid got %b required %b", name, t, sample_valid, e_valid);
            end
            checks++;
            if (busy !== e_busy) begin
                errors++;
                $display("[TB] FAIL %s t=%0d busy got %b required %b", name, t, busy, e_busy);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("[TB] FAIL %s t=%0d done got %b required %b", name, t, done, e_done);
            end

            // Requests driven here are sampled on the edge that ends cycle t
            stop   = (t == stop_at);
            start  = (t == start_at);
            cfg_we = (t == cfgwe_at);
            if (t == cfgwe_at) cfg_freq = 16'h1234;
        end
        stop   = 1'b0;
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        int ns, nw, nd;
        @(negedge clk);
        checks++;
        if ({count, sample_strobe, wrap, sample_valid, busy, done} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL power_on_reset outputs got %h required 0",
                     {count, sample_strobe, wrap, sample_valid, busy, done});
        end
        // Reset in the middle of a run
        program_cfg(16'h0080, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 9'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset count got %0d required 0", count);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset busy/done got %b%b required 00", busy, done);
        end
        checks++;
        if (sample_strobe !== 1'b0 || sample_valid !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset strobe/valid/wrap got %b%b%b required 000",
                     sample_strobe, sample_valid, wrap);
        end
        // Configuration was cleared: freq 0 holds count at 0
        run_scenario("after_reset", 0, 0, 0, 1'b0, 20, -1, -1, 1'b0, ns, nw, nd);
        checks++;
        if (nw != 0) begin
            errors++;
            $display("[TB] FAIL after_reset wraps got %0d required 0", nw);
        end
    endtask

    task automatic test_continuous();
        int ns, nw, nd;
        program_cfg(16'h0080, 0, 0, 1'b0);
        run_scenario("continuous", 16'h0080, 0, 0, 1'b0, 520, -1, -1, 1'b0, ns, nw, nd);
        checks++;
        if (ns != 521 || nw != 1) begin
            errors++;
            $display("[TB] FAIL continuous strobes/wraps got %0d/%0d required 521/1", ns, nw);
        end
    endtask

    task automatic test_prescaler();
        int ns, nw, nd;
        program_cfg(16'h0080, 3, 0, 1'b0);
        run_scenario("prescaler", 16'h0080, 3, 0, 1'b0, 40, -1, -1, 1'b0, ns, nw, nd);
        checks++;
        if (ns != 11) begin
            errors++;
            $display("[TB] FAIL prescaler strobes got %0d required 11", ns);
        end
    endtask

    task automatic test_burst();
        int ns, nw, nd;
        program_cfg(16'h4000, 0, 2, 1'b1);
        run_scenario("burst", 16'h4000, 0, 2, 1'b1, -1, -1, -1, 1'b0, ns, nw, nd);
        checks++;
        if (ns != 8 || nw != 1 || nd != 1) begin
            errors++;
            $display("[TB] FAIL burst strobes/wraps/dones got %0d/%0d/%0d required 8/1/1", ns, nw, nd);
        end
    endtask

    task automatic test_stop_and_cfg();
        int ns, nw, nd;
        program_cfg(16'h0080, 3, 0, 1'b0);
        // stop at cycle 7 coincides with the tick on the edge ending it;
        // cfg_we at cycle 2 must not change the step size
        run_scenario("stop_on_tick", 16'h0080, 3, 0, 1'b0, 7, -1, 2, 1'b0, ns, nw, nd);
        checks++;
        if (ns != 2 || nd != 1) begin
            errors++;
            $display("[TB] FAIL stop_on_tick strobes/dones got %0d/%0d required 2/1", ns, nd);
        end
    endtask

    task automatic test_start_stop_collision();
        int ns, nw, nd;
        program_cfg(16'h0100, 1, 0, 1'b0);
        run_scenario("collision", 16'h0100, 1, 0, 1'b0, 30, 5, -1, 1'b1, ns, nw, nd);
        checks++;
        if (ns != 16) begin
            errors++;
            $display("[TB] FAIL collision strobes got %0d required 16", ns);
        end
    endtask

    task automatic test_random();
        int ns, nw, nd, freq, div, cyc, stop_at;
        bit bst;
        for (int i = 0; i < 6; i++) begin
            freq = int'($urandom_range(16'hFFFF, 16'h0800));
            div  = int'($urandom_range(3, 0));
            cyc  = int'($urandom_range(3, 0));
            bst  = 1'($urandom_range(1, 0));
            if (bst && $urandom_range(1, 0) == 1) stop_at = -1;
            else stop_at = int'($urandom_range(300, 5));
            program_cfg(freq, div, cyc, bst);
            run_scenario($sformatf("random%0d", i), freq, div, cyc, bst, stop_at, -1, -1, 1'b0, ns, nw, nd);
            checks++;
            if (nd != 1) begin
                errors++;
                $display("[TB] FAIL random%0d dones got %0d required 1", i, nd);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_freq   = '0;
        cfg_div    = '0;
        cfg_cycles = '0;
        cfg_burst  = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_continuous();
        test_prescaler();
        test_burst();
        test_stop_and_cfg();
        test_start_stop_collision();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
